// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: SCAN (collective) elevator controller.
// Calls are latched into a pending-floor mask. The car keeps moving in its
// current direction while calls remain ahead, stops with the door open at
// each called floor, then reverses or idles.
// Optional feature macro: ELEV_DOOR_REOPEN_EN. When defined, a call for the
// current floor while the door is open restarts the door timer.
module elevator_scan_ctrl #(
    parameter int NUM_FLOORS   = 10,
    parameter int FLOOR_W      = 4,
    parameter int TRAVEL_TICKS = 100000,
    parameter int DOOR_TICKS   = 200000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  call_valid,
    input  logic [FLOOR_W-1:0]    call_floor,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic                  idle
);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

    localparam logic [31:0] TRAVEL_LAST = 32'(TRAVEL_TICKS - 1);
    localparam logic [31:0] DOOR_LAST   = 32'(DOOR_TICKS - 1);

    state_t                  state, state_nx;
    state_t                  dec_state;
    logic                    dec_dir;
    logic [31:0]             timer, timer_nx;
    logic [FLOOR_W-1:0]      floor_nx, step_floor;
    logic [NUM_FLOORS-1:0]   pending_nx, pending_call, call_mask, step_mask;
    logic                    dir_nx;
    logic                    call_ok, call_here, call_sets;
    logic                    up_here, dn_here;
    logic                    step_hit, go_on, go_back;

    function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_FLOORS; i++) m[i] = (int'(f) == i);
        return m;
    endfunction

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) if (i > int'(f) && p[i]) r = 1'b1;
        return r;
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) if (i < int'(f) && p[i]) r = 1'b1;
        return r;
    endfunction

    // Out-of-range floors are dropped; a call for the floor the car is parked
    // at (IDLE) or standing at with the door open never becomes pending.
    assign call_ok   = call_valid && (int'(call_floor) < NUM_FLOORS);
    assign call_here = call_ok && (call_floor == current_floor);
    assign call_sets = call_ok && !(call_here && (state == IDLE || state == DOOR));
    assign call_mask = floor_mask(call_floor);
    assign pending_call = call_sets ? (pending | call_mask) : pending;

    // The floor reached at the end of the current travel leg. Arrival checks
    // include a call latched on that same edge, so it is absorbed by the stop.
    assign step_floor = (state == MOVE_UP) ? current_floor + FLOOR_W'(1)
                                           : current_floor - FLOOR_W'(1);
    assign step_mask  = floor_mask(step_floor);
    assign step_hit   = |(pending_call & step_mask);
    assign go_on      = (state == MOVE_UP) ? any_above(pending_call, step_floor)
                                           : any_below(pending_call, step_floor);
    assign go_back    = (state == MOVE_UP) ? any_below(pending_call, step_floor)
                                           : any_above(pending_call, step_floor);

    assign up_here = any_above(pending, current_floor);
    assign dn_here = any_below(pending, current_floor);

    // Departure decision from a standstill: prefer the current direction.
    always_comb begin
        dec_state = IDLE;
        dec_dir   = dir_up;
        if (dir_up && up_here) begin
            dec_state = MOVE_UP;
        end else if (!dir_up && dn_here) begin
            dec_state = MOVE_DOWN;
        end else if (up_here) begin
            dec_state = MOVE_UP;
            dec_dir   = 1'b1;
        end else if (dn_here) begin
            dec_state = MOVE_DOWN;
            dec_dir   = 1'b0;
        end
    end

    // Next-state, floor, direction, timer and pending-mask logic.
    always_comb begin
        state_nx   = state;
        floor_nx   = current_floor;
        dir_nx     = dir_up;
        timer_nx   = timer;
        pending_nx = pending_call;
        case (state)
            IDLE: begin
                if (call_here) begin
                    state_nx = DOOR;
                    timer_nx = '0;
                end else begin
                    state_nx = dec_state;
                    dir_nx   = dec_dir;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (timer == TRAVEL_LAST) begin
                    timer_nx = '0;
                    floor_nx = step_floor;
                    if (step_hit) begin
                        state_nx   = DOOR;
                        pending_nx = pending_call & ~step_mask;
                    end else if (go_on) begin
                        state_nx = state;
                    end else if (go_back) begin
                        state_nx = (state == MOVE_UP) ? MOVE_DOWN : MOVE_UP;
                        dir_nx   = (state != MOVE_UP);
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    timer_nx = timer + 32'd1;
                end
            end
            DOOR: begin
                if (timer == DOOR_LAST) begin
                    timer_nx = '0;
                    state_nx = dec_state;
                    dir_nx   = dec_dir;
                end else begin
                    timer_nx = timer + 32'd1;
                end
`ifdef ELEV_DOOR_REOPEN_EN
                if (call_here) begin
                    timer_nx = '0;
                    state_nx = DOOR;
                    dir_nx   = dir_up;
                end
`endif
            end
            default: begin
                state_nx = IDLE;
                timer_nx = '0;
            end
        endcase
    end

    // State register; reset drops every pending call.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            current_floor <= '0;
            pending       <= '0;
            dir_up        <= 1'b1;
        end else begin
            state         <= state_nx;
            timer         <= timer_nx;
            current_floor <= floor_nx;
            pending       <= pending_nx;
            dir_up        <= dir_nx;
        end
    end

    assign moving    = (state == MOVE_UP) || (state == MOVE_DOWN);
    assign door_open = (state == DOOR);
    assign idle      = (state == IDLE);

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Testbench for elevator_scan_ctrl: directed scenarios plus random calls,
// checked cycle by cycle against a countdown-based behavioural model through
// an expected-value queue. Honours ELEV_DOOR_REOPEN_EN like the design.
`timescale 1ns/1ps
module tb_elevator_scan_ctrl;
    localparam int NF = 8;
    localparam int FW = 4;
    localparam int TT = 4;
    localparam int DT = 3;
`ifdef ELEV_DOOR_REOPEN_EN
    localparam bit REOPEN = 1'b1;
    localparam int EXP_DOOR_RE = 5;
`else
    localparam bit REOPEN = 1'b0;
    localparam int EXP_DOOR_RE = 3;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          call_valid = 1'b0;
    logic [FW-1:0] call_floor = '0;
    logic [FW-1:0] current_floor;
    logic [NF-1:0] pending;
    logic          dir_up, moving, door_open, idle;

    elevator_scan_ctrl #(
        .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_TICKS(TT), .DOOR_TICKS(DT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .call_valid(call_valid), .call_floor(call_floor),
        .current_floor(current_floor), .pending(pending), .dir_up(dir_up),
        .moving(moving), .door_open(door_open), .idle(idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        int          cyc;
        logic [15:0] v;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: car position, direction as +1/-1, and remaining
    // travel / door cycles (both zero means the car is idle).
    int m_floor, m_dir, m_travel_left, m_door_left;
    bit m_pend[NF];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic bit calls_beyond(input int from, input int d);
        for (int f = 0; f < NF; f++)
            if (m_pend[f] && (f - from) * d > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_floor = 0; m_dir = 1; m_travel_left = 0; m_door_left = 0;
        for (int f = 0; f < NF; f++) m_pend[f] = 1'b0;
    endtask

    task automatic depart();
        bit up, dn;
        up = calls_beyond(m_floor, 1);
        dn = calls_beyond(m_floor, -1);
        if (m_dir > 0 && up) m_travel_left = TT;
        else if (m_dir < 0 && dn) m_travel_left = TT;
        else if (up) begin m_dir = 1; m_travel_left = TT; end
        else if (dn) begin m_dir = -1; m_travel_left = TT; end
    endtask

    task automatic model_step(input bit cv, input int cf);
        bit ok, here;
        ok = cv && (cf < NF);
        here = ok && (cf == m_floor);
        if (m_travel_left > 0) begin
            if (ok) m_pend[cf] = 1'b1;
            m_travel_left--;
            if (m_travel_left == 0) begin
                m_floor += m_dir;
                if (m_pend[m_floor]) begin
                    m_pend[m_floor] = 1'b0;
                    m_door_left = DT;
                end else if (calls_beyond(m_floor, m_dir)) begin
                    m_travel_left = TT;
                end else if (calls_beyond(m_floor, -m_dir)) begin
                    m_dir = -m_dir;
                    m_travel_left = TT;
                end
            end
        end else if (m_door_left > 0) begin
            if (REOPEN && here) m_door_left = DT;
            else begin
                m_door_left--;
                if (m_door_left == 0) depart();
            end
            if (ok && !here) m_pend[cf] = 1'b1;
        end else begin
            if (here) m_door_left = DT;
            else begin
                depart();
                if (ok) m_pend[cf] = 1'b1;
            end
        end
    endtask

    function automatic logic [15:0] model_vec();
        logic [NF-1:0] p;
        logic b_dir, b_mov, b_door, b_idle;
        for (int f = 0; f < NF; f++) p[f] = m_pend[f];
        b_dir  = (m_dir > 0);
        b_mov  = (m_travel_left > 0);
        b_door = (m_door_left > 0);
        b_idle = (m_travel_left == 0) && (m_door_left == 0);
        return {FW'(m_floor), p, b_dir, b_mov, b_door, b_idle};
    endfunction

    function automatic bit model_idle();
        return (m_travel_left == 0) && (m_door_left == 0);
    endfunction

    // Drive one cycle of stimulus, queue the model's expectation for the
    // coming edge, and return just after that edge.
    task automatic tick(input bit cv, input int cf);
        exp_t e;
        @(negedge clk);
        call_valid = cv;
        call_floor = FW'(cf);
        model_step(cv, cf);
        e.cyc = cyc_cnt + 1;
        e.v = model_vec();
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        call_valid = 1'b0;
        #1;
        chk("rst_floor", 32'(current_floor), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_dir_up", 32'(dir_up), 1);
        chk("rst_idle", 32'(idle), 1);
        chk("rst_moving", 32'(moving), 0);
        chk("rst_door", 32'(door_open), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare every expectation whose edge has already happened.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
                e = exp_q.pop_front();
                checks++;
                if ({current_floor, pending, dir_up, moving, door_open, idle} !== e.v) begin
                    failures++;
                    $display("FAIL scoreboard cyc=%0d: got floor=%0d pend=%h dir=%b mov=%b door=%b idle=%b expected floor=%0d pend=%h dir=%b mov=%b door=%b idle=%b",
                             e.cyc, current_floor, pending, dir_up, moving, door_open, idle,
                             e.v[15:12], e.v[11:4], e.v[3], e.v[2], e.v[1], e.v[0]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d, doors;
        bit prev;
        model_reset();

        // Single call to floor 3 from reset.
        do_reset();
        tick(1, 3);
        chk("a_pending_latched", 32'(pending), 32'h08);
        chk("a_idle_same_edge", 32'(idle), 1);
        tick(0, 0);
        chk("a_moving", 32'(moving), 1);
        n = 1;
        while (!door_open && n < 100) begin tick(0, 0); n++; end
        chk("a_arrival_cycles", n, 3 * TT + 1);
        chk("a_floor", 32'(current_floor), 3);
        d = 0;
        while (door_open && d < 100) begin d++; tick(0, 0); end
        chk("a_door_cycles", d, DT);
        chk("a_idle_after", 32'(idle), 1);
        chk("a_pending_after", 32'(pending), 0);

        // Out-of-range calls are ignored.
        tick(1, 9);
        chk("b_pend_9", 32'(pending), 0);
        chk("b_idle_9", 32'(idle), 1);
        tick(1, 8);
        chk("b_pend_8", 32'(pending), 0);
        chk("b_idle_8", 32'(idle), 1);

        // Call at the parked floor opens the door; repeat call in its second cycle.
        tick(1, 3);
        chk("c_door_next", 32'(door_open), 1);
        chk("c_pend_here", 32'(pending), 0);
        d = 1;
        tick(0, 0);
        d++;
        tick(1, 3);
        while (door_open && d < 100) begin d++; tick(0, 0); end
        chk("c_door_reopen_cycles", d, EXP_DOOR_RE);
        chk("c_pend_after", 32'(pending), 0);

        // Pick up floor 2 on the way to 5.
        do_reset();
        tick(1, 5);
        n = 0;
        while (m_floor != 1 && n < 200) begin tick(0, 0); n++; end
        chk("d_reach1", 32'(n < 200), 1);
        tick(1, 2);
        n = 0; doors = 0; prev = door_open;
        while (!model_idle() && n < 300) begin
            tick(0, 0); n++;
            if (door_open && !prev) doors++;
            prev = door_open;
        end
        chk("d_stops", doors, 2);
        chk("d_floor", 32'(current_floor), 5);
        chk("d_dir_up", 32'(dir_up), 1);

        // Call behind the car while heading for 6: serve 6, reverse, serve 1.
        do_reset();
        tick(1, 6);
        n = 0;
        while (m_floor != 2 && n < 200) begin tick(0, 0); n++; end
        chk("e_reach2", 32'(n < 200), 1);
        tick(1, 1);
        n = 0; doors = 0; prev = door_open;
        while (!model_idle() && n < 300) begin
            tick(0, 0); n++;
            if (door_open && !prev) doors++;
            prev = door_open;
        end
        chk("e_stops", doors, 2);
        chk("e_floor", 32'(current_floor), 1);
        chk("e_dir_up", 32'(dir_up), 0);
        chk("e_pending", 32'(pending), 0);

        // Asynchronous reset while moving at floor 4 with calls for 6 and 7.
        do_reset();
        tick(1, 6);
        tick(1, 7);
        n = 0;
        while (m_floor != 4 && n < 200) begin tick(0, 0); n++; end
        chk("f_pending_c0", 32'(pending), 32'hC0);
        chk("f_moving", 32'(moving), 1);
        do_reset();

        // Random traffic including out-of-range floors.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) tick(1, int'($urandom_range(0, 9)));
            else tick(0, int'($urandom_range(0, 15)));
        end
        n = 0;
        while (!model_idle() && n < 500) begin tick(0, 0); n++; end
        chk("g_settle", 32'(n < 500), 1);
        chk("g_pending_empty", 32'(pending), 0);

        n = 0;
        while (exp_q.size() > 0 && n < 10) begin @(negedge clk); #1; n++; end
        chk("drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/elevator_scan_ctrl.md
# elevator_scan_ctrl

Parametrised multi-call elevator controller serving up to NUM_FLOORS floors with a SCAN (collective) policy. Calls are latched into a pending-floor bitmask; the car keeps moving in its current direction while calls remain ahead, stops and dwells with the door open at each called floor, then reverses or idles. It sits between the board's call inputs and the floor display decoder, and exposes current floor, direction, door and pending state.

## Interface
- NUM_FLOORS, 10, number of floors served (0..NUM_FLOORS-1); 2..16
- FLOOR_W, 4, floor index width; must satisfy 2^FLOOR_W >= NUM_FLOORS
- TRAVEL_TICKS, 100000, clk cycles to move one floor; >= 1
- DOOR_TICKS, 200000, clk cycles the door stays open per stop; >= 1

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- call_valid  in  1  call strobe, sampled each rising clk edge
- call_floor  in  FLOOR_W  floor requested when call_valid=1
- current_floor  out  FLOOR_W  floor the car is at or last passed
- pending  out  NUM_FLOORS  bit f set = call for floor f outstanding
- dir_up  out  1  1 = up / last direction was up, 0 = down
- moving  out  1  1 in MOVE_UP or MOVE_DOWN
- door_open  out  1  1 in DOOR
- idle  out  1  1 in IDLE

## Operation
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR. moving/door_open/idle decoded from state only.
- Call capture: call_valid with call_floor < NUM_FLOORS sets pending[call_floor]; call_floor >= NUM_FLOORS ignored. Exception: call for current_floor in IDLE or DOOR never sets pending (see below).
- ahead_up = any pending bit above reference floor; ahead_dn = any below.
- Decide rule (used from IDLE and at DOOR end, reference = current_floor): if dir_up and ahead_up -> MOVE_UP; else if !dir_up and ahead_dn -> MOVE_DOWN; else if ahead_up -> MOVE_UP, dir_up=1; else if ahead_dn -> MOVE_DOWN, dir_up=0; else IDLE.
- IDLE: call for current_floor -> DOOR; otherwise apply decide rule on pending.
- MOVE: single 32-bit timer counts 0..TRAVEL_TICKS-1; at terminal count floor steps +/-1 (new floor = f'), timer clears. If pending[f'] -> DOOR, clear pending[f']; else if calls remain ahead of f' in current direction -> stay; else if calls on other side -> reverse direction (state and dir_up); else IDLE.
- DOOR: timer counts 0..DOOR_TICKS-1, then decide rule.
- Car never moves below 0 or above NUM_FLOORS-1 (no pending bits exist beyond).
- Call for f' on the same edge it is cleared at arrival: absorbed, bit ends 0.

## Timing
- Reset values: current_floor=0, pending=0, dir_up=1, state IDLE (idle=1, moving=0, door_open=0), timer 0.
- Reset mid-operation: all state cleared asynchronously; pending calls lost.
- Call accepted at edge t -> pending visible after t; IDLE leaves at edge t+1.
- One floor takes exactly TRAVEL_TICKS cycles in MOVE; door_open high exactly DOOR_TICKS cycles per stop (without reopen).
- Direction change occurs only on the floor-step edge or at DOOR/IDLE decision; never mid-travel.

## Configuration
- ELEV_DOOR_REOPEN_EN defined: call for current_floor during DOOR clears the door timer to 0 (door held open another DOOR_TICKS cycles).
- Undefined: such calls ignored; door closes on original schedule.

## Test plan
(NUM_FLOORS=8, TRAVEL_TICKS=4, DOOR_TICKS=3)
- Reset, call 3 -> pending=0x08, MOVE_UP, floor 1,2,3 every 4 cycles, door_open 3 cycles, then IDLE, pending=0x00.
- Call 5 from floor 0, then call 2 while at floor 1 -> stops at 2 (door 3 cycles), continues to 5; dir_up stays 1.
- At floor 2 moving to 6, call 1 -> serves 6, reverses (dir_up=0), serves 1, IDLE.
- call_floor=9 -> pending unchanged, state unchanged.
- IDLE at 0, call 0 -> door_open next cycle for 3 cycles; repeat call 0 in DOOR second cycle -> 5 cycles open with ELEV_DOOR_REOPEN_EN, 3 without.
- rst_n low while moving at floor 4 with pending=0xC0 -> immediately floor 0, pending 0, idle=1.
